// File: rtl/decoder.sv
// decoder: binary select code to one-hot line selects, gated by a valid input.
// Out-of-range codes (only reachable when NUM_WIRE is not a power of two)
// assert no line and raise a_err_o instead. With OUT_REG=1 both outputs are
// flopped for a glitch-free select bus with one cycle of latency; with
// OUT_REG=0 they are a single combinational compare-and-AND level.
module decoder #(
    parameter int NUM_WIRE = 4,
    parameter int OUT_REG  = 1,
    localparam int AW      = $clog2(NUM_WIRE)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [AW-1:0]       a_i,
    input  logic                a_valid_i,
    output logic [NUM_WIRE-1:0] d_o,
    output logic                a_err_o
);

    logic [NUM_WIRE-1:0] w_d;
    logic                w_err;

    // Decode; the valid gate sits outside the compare so an unknown code
    // presented while a_valid_i is low still produces all-zero outputs.
    always_comb begin
        w_d   = '0;
        w_err = 1'b0;
        if (a_valid_i) begin
            for (int i = 0; i < NUM_WIRE; i++) begin
                w_d[i] = (32'(a_i) == i);
            end
            w_err = (32'(a_i) >= NUM_WIRE);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [NUM_WIRE-1:0] r_d;
            logic                r_err;

            // Output register reloaded every edge; reset drops the active line at once.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_d   <= '0;
                    r_err <= 1'b0;
                end else begin
                    r_d   <= w_d;
                    r_err <= w_err;
                end
            end

            assign d_o     = r_d;
            assign a_err_o = r_err;
        end else begin : g_comb
            // Clock and reset have no function in the combinational build.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk_i ^ rst_i;

            assign d_o     = w_d;
            assign a_err_o = w_err;
        end
    endgenerate

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: registered NUM_WIRE=4 and NUM_WIRE=5
// instances plus a combinational NUM_WIRE=8 instance, checked against an
// arithmetic reference model.
module tb_decoder;

    logic       clk;
    logic       rst;
    logic [1:0] a4;
    logic       v4;
    logic [3:0] d4;
    logic       e4;
    logic [2:0] a5;
    logic       v5;
    logic [4:0] d5;
    logic       e5;
    logic [2:0] a8;
    logic       v8;
    logic [7:0] d8;
    logic       e8;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_d4, exp_d5, exp_d8;
    logic        exp_e4, exp_e5, exp_e8;

    decoder #(.NUM_WIRE(4), .OUT_REG(1)) u_dec4 (
        .clk_i(clk), .rst_i(rst), .a_i(a4), .a_valid_i(v4), .d_o(d4), .a_err_o(e4)
    );
    decoder #(.NUM_WIRE(5), .OUT_REG(1)) u_dec5 (
        .clk_i(clk), .rst_i(rst), .a_i(a5), .a_valid_i(v5), .d_o(d5), .a_err_o(e5)
    );
    decoder #(.NUM_WIRE(8), .OUT_REG(0)) u_dec8 (
        .clk_i(clk), .rst_i(rst), .a_i(a8), .a_valid_i(v8), .d_o(d8), .a_err_o(e8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the addressed line is 2**a when enabled and in range.
    function automatic logic [31:0] mdl_d(input int n, input int a, input bit v);
        if (v && a < n) return 32'd1 << a;
        return 32'd0;
    endfunction

    function automatic logic mdl_e(input int n, input int a, input bit v);
        return v && (a >= n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with a live select code present
        rst = 1'b1;
        a4 = 2'd2; v4 = 1'b1;
        a5 = 3'd0; v5 = 1'b0;
        a8 = 3'd0; v8 = 1'b0;
        #1;
        chk("rst_imm_d4", 32'(d4), 32'd0);
        chk("rst_imm_e4", 32'(e4), 32'd0);
        chk("rst_imm_d5", 32'(d5), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_hold_d4", 32'(d4), 32'd0);
            chk("rst_hold_e4", 32'(e4), 32'd0);
        end
        rst = 1'b0;
        chk("rst_rel_noedge_d4", 32'(d4), 32'd0);
        tick();
        chk("rst_first_d4", 32'(d4), 32'b0100);

        // exhaustive sweep, enabled then disabled
        for (int v = 1; v >= 0; v--) begin
            for (int a = 0; a < 4; a++) begin
                a4 = 2'(a); v4 = 1'(v);
                tick();
                chk("sweep_d4", 32'(d4), mdl_d(4, a, v[0]));
                chk("sweep_e4", 32'(e4), 32'd0);
            end
        end

        // unknown code while disabled must not leak
        a4 = 2'bxx; v4 = 1'b0;
        a8 = 3'bxxx; v8 = 1'b0;
        #1;
        chk("x_comb_d8", 32'(d8), 32'd0);
        chk("x_comb_e8", 32'(e8), 32'd0);
        tick();
        chk("x_reg_d4", 32'(d4), 32'd0);
        chk("x_reg_e4", 32'(e4), 32'd0);

        // non-power-of-two directed codes
        for (int a = 4; a < 8; a++) begin
            a5 = 3'(a); v5 = 1'b1;
            tick();
            chk("np2_d5", 32'(d5), (a == 4) ? 32'b10000 : 32'd0);
            chk("np2_e5", 32'(e5), (a == 4) ? 32'd0 : 32'd1);
        end
        for (int a = 0; a < 8; a++) begin
            a5 = 3'(a); v5 = 1'b0;
            tick();
            chk("np2_off_d5", 32'(d5), 32'd0);
            chk("np2_off_e5", 32'(e5), 32'd0);
        end

        // combinational build, no clock edge involved
        @(negedge clk);
        a8 = 3'd6; v8 = 1'b1;
        #1;
        chk("comb_d8_on", 32'(d8), 32'b0100_0000);
        chk("comb_e8_on", 32'(e8), 32'd0);
        v8 = 1'b0;
        #1;
        chk("comb_d8_off", 32'(d8), 32'd0);
        tick();

        // randomized streaming against the model, outputs delayed one edge
        for (int k = 0; k < 1000; k++) begin
            a4 = 2'($urandom_range(0, 3));  v4 = 1'($urandom);
            a5 = 3'($urandom_range(0, 7));  v5 = 1'($urandom);
            a8 = 3'($urandom_range(0, 7));  v8 = 1'($urandom);
            exp_d4 = mdl_d(4, int'(a4), v4); exp_e4 = mdl_e(4, int'(a4), v4);
            exp_d5 = mdl_d(5, int'(a5), v5); exp_e5 = mdl_e(5, int'(a5), v5);
            exp_d8 = mdl_d(8, int'(a8), v8); exp_e8 = mdl_e(8, int'(a8), v8);
            #1;
            chk("rnd_d8", 32'(d8), exp_d8);
            chk("rnd_e8", 32'(e8), 32'(exp_e8));
            tick();
            chk("rnd_d4", 32'(d4), exp_d4);
            chk("rnd_e4", 32'(e4), 32'(exp_e4));
            chk("rnd_d5", 32'(d5), exp_d5);
            chk("rnd_e5", 32'(e5), 32'(exp_e5));
            chk("rnd_onehot_d5", 32'($countones(d5) <= 1), 32'd1);
        end

        // mid-stream asynchronous reset
        a4 = 2'd1; v4 = 1'b1;
        tick();
        chk("mid_d4_1", 32'(d4), 32'b0010);
        a4 = 2'd3;
        tick();
        chk("mid_d4_3", 32'(d4), 32'b1000);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_d4", 32'(d4), 32'd0);
        chk("mid_rst_e4", 32'(e4), 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("mid_rel_d4", 32'(d4), 32'd0);
        a4 = 2'd0;
        tick();
        chk("mid_resume_d4", 32'(d4), 32'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
